// File: rtl/boot_pkg.sv
// boot_pkg: FSM state encoding and framing constants shared by the boot loader
// and its word packer.
package boot_pkg;

  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } boot_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int LANE_W     = 8;
  localparam int WORD_LANES = 4;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_bytes(input boot_state_t s);
    return (s == S_ADDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/boot_word_pack.sv
// boot_word_pack: gathers payload bytes into little-endian words with byte
// strobes and emits a single-cycle write when a word fills or the image ends.
module boot_word_pack
  import boot_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_last,
  input  logic [1:0]                   i_lane,
  input  logic [LANE_W-1:0]            i_byte,
  input  logic [31:0]                  i_addr,
  output logic                         o_we,
  output logic [31:0]                  o_addr,
  output logic [LANE_W*WORD_LANES-1:0] o_data,
  output logic [WORD_LANES-1:0]        o_strb
);

  logic [LANE_W*WORD_LANES-1:0] r_acc;
  logic [WORD_LANES-1:0]        r_acc_strb;
  logic [LANE_W*WORD_LANES-1:0] w_data;
  logic [WORD_LANES-1:0]        w_strb;
  logic                         w_flush;

  // The incoming byte is merged combinationally so a full word can be
  // written in the same edge that accepts its last byte.
  generate
    for (genvar gi = 0; gi < WORD_LANES; gi++) begin : g_lane
      assign w_data[gi*LANE_W +: LANE_W] = (i_lane == 2'(gi)) ? i_byte
                                                             : r_acc[gi*LANE_W +: LANE_W];
      assign w_strb[gi] = (i_lane == 2'(gi)) | r_acc_strb[gi];
    end
  endgenerate

  assign w_flush = i_last | (i_lane == 2'(WORD_LANES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_acc_strb <= '0;
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
      o_strb     <= '0;
    end else begin
      o_we <= 1'b0;
      if (i_push) begin
        if (w_flush) begin
          o_we       <= 1'b1;
          o_addr     <= i_addr;
          o_data     <= w_data;
          o_strb     <= w_strb;
          r_acc      <= '0;
          r_acc_strb <= '0;
        end else begin
          r_acc      <= w_data;
          r_acc_strb <= w_strb;
        end
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a framed image (base, length, payload) over a byte
// stream, writes it to RAM and releases the core. BOOT_LOADER_CHECKSUM_EN adds an XOR trailer.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0000_2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        core_rst_n,
  output logic        done,
  output logic        err
);

  localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_t S_PAY_END = S_CSUM;
  logic [7:0] r_csum;
`else
  localparam boot_state_t S_PAY_END = S_DONE;
`endif

  boot_state_t r_state;
  boot_state_t w_state_next;
  logic [31:0] r_base;
  logic [31:0] r_len;
  logic [31:0] r_idx;
  logic [1:0]  r_hdr_cnt;
  logic        r_rx_ready;
  logic        r_core_rst_n;

  logic        w_accept;
  logic        w_push;
  logic        w_hdr_last;
  logic        w_pay_last;
  logic [31:0] w_base_full;
  logic [31:0] w_len_full;
  logic [32:0] w_end;
  logic [31:0] w_word_addr;

  assign w_accept    = rx_valid & r_rx_ready;
  assign w_push      = w_accept & (r_state == S_DATA);
  assign w_hdr_last  = (r_hdr_cnt == 2'(HDR_BYTES - 1));
  assign w_base_full = {rx_data, r_base[23:0]};
  assign w_len_full  = {rx_data, r_len[23:0]};
  assign w_end       = {1'b0, r_base} + {1'b0, w_len_full};
  assign w_pay_last  = (r_idx == r_len - 32'd1);
  assign w_word_addr = r_base + {r_idx[31:2], 2'b00};

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        S_ADDR: if (w_hdr_last) begin
          if ((w_base_full[1:0] != 2'b00) || (w_base_full < MEM_BASE)) w_state_next = S_ERR;
          else w_state_next = S_LEN;
        end
        S_LEN: if (w_hdr_last) begin
          if (w_end > MEM_END) w_state_next = S_ERR;
          else if (w_len_full == 32'd0) w_state_next = S_PAY_END;
          else w_state_next = S_DATA;
        end
        S_DATA: if (w_pay_last) w_state_next = S_PAY_END;
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_data == r_csum) w_state_next = S_DONE;
          else w_state_next = S_ERR;
        end
`endif
        default: w_state_next = r_state;
      endcase
    end
  end

  // When the final payload byte enters S_DONE, the core is released one
  // cycle later so it never sees RAM before the last write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_ADDR;
      r_base       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_hdr_cnt    <= '0;
      r_rx_ready   <= 1'b0;
      r_core_rst_n <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_rx_ready   <= accepts_bytes(w_state_next);
      r_core_rst_n <= r_core_rst_n | (r_state == S_DONE)
                    | ((w_state_next == S_DONE) & ~w_push);
      if (w_accept) begin
        case (r_state)
          S_ADDR: begin
            r_base[{r_hdr_cnt, 3'b000} +: 8] <= rx_data;
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
          end
          S_LEN: begin
            r_len[{r_hdr_cnt, 3'b000} +: 8] <= rx_data;
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
          end
          S_DATA: begin
            r_idx <= r_idx + 32'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  boot_word_pack u_pack (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_last (w_pay_last),
    .i_lane (r_idx[1:0]),
    .i_byte (rx_data),
    .i_addr (w_word_addr),
    .o_we   (mem_we),
    .o_addr (mem_addr),
    .o_data (mem_wdata),
    .o_strb (mem_wstrb)
  );

  assign rx_ready   = r_rx_ready;
  assign core_rst_n = r_core_rst_n;
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed and randomized frames against a frame-level model
// of the loader (header checks, word chunking, release timing).
module tb_boot_loader;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0000_2024;
  localparam longint unsigned MEM_END = 64'(MEM_BASE) + 64'(MEM_SIZE);
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        core_rst_n;
  logic        done;
  logic        err;

  boot_loader #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .core_rst_n(core_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0]  tx_q[$];
  logic [67:0] exp_q[$];
  logic [67:0] act_q[$];
  bit          exp_done, exp_err;
  int          exp_acc;
  int          done_cyc, rstn_cyc, last_we_cyc, last_acc_cyc;
  bit          done_at_we, rstn_during_we;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        act_q.push_back({mem_addr, mem_wdata, mem_wstrb});
        last_we_cyc = cyc;
        done_at_we  = done;
        if (core_rst_n) rstn_during_we = 1'b1;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (core_rst_n && rstn_cyc < 0) rstn_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    #1;
    check_val("rst_rx_ready", rx_ready, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_mem_wstrb", mem_wstrb, 0);
    check_val("rst_core_rst_n", core_rst_n, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    @(posedge clk); #1;
    act_q.delete();
    done_cyc = -1; rstn_cyc = -1; last_we_cyc = -1; last_acc_cyc = -1;
    done_at_we = 1'b0; rstn_during_we = 1'b0;
    rst = 1'b0;
    check_val("ready_after_rst", rx_ready, 0);
    @(posedge clk); #1;
    check_val("ready_rise", rx_ready, 1);
  endtask

  // Present one byte; it is taken at the first edge where rx_ready was high.
  task automatic send_byte(input logic [7:0] b, input int max_wait, output bit acc);
    bit will;
    acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < max_wait; n++) begin
      will = rx_ready;
      @(posedge clk); #1;
      if (will) begin
        acc = 1'b1;
        last_acc_cyc = cyc;
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic build_header(input logic [31:0] base, input logic [31:0] len);
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(base >> (8 * i)));
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(len >> (8 * i)));
  endtask

  task automatic add_payload(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic add_trailer(input bit bad);
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 8; i < tx_q.size(); i++) x ^= tx_q[i];
    tx_q.push_back(x ^ {7'b0, bad});
`else
    if (bad) tx_q.push_back(8'h00);
`endif
  endtask

  // Frame-level reference: what the spec says this byte sequence must produce.
  task automatic model_frame();
    logic [31:0] base, len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  x;
    longint unsigned e;
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    base = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
    if (base[1:0] != 2'b00 || base < MEM_BASE) begin
      exp_err = 1'b1; exp_acc = 4; return;
    end
    len = {tx_q[7], tx_q[6], tx_q[5], tx_q[4]};
    e = 64'(base) + 64'(len);
    if (e > MEM_END) begin
      exp_err = 1'b1; exp_acc = 8; return;
    end
    x = 8'h00;
    for (int w = 0; w * 4 < int'(len); w++) begin
      data = 32'h0; strb = 4'h0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < int'(len)) begin
          data = data | (32'(tx_q[8 + w * 4 + l]) << (8 * l));
          strb = strb | 4'(1 << l);
          x = x ^ tx_q[8 + w * 4 + l];
        end
      end
      exp_q.push_back({base + 32'(w * 4), data, strb});
    end
    exp_acc = 8 + int'(len);
    if (CSUM_EN) begin
      exp_acc++;
      if (tx_q[8 + int'(len)] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
    end else begin
      exp_done = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input int gap_mode);
    int  acc_n = 0;
    int  gap;
    bit  ok;
    int  nw;
    model_frame();
    foreach (tx_q[i]) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      send_byte(tx_q[i], 6, ok);
      if (!ok) break;
      acc_n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    check_val({tag, "_accepted"}, acc_n, exp_acc);
    check_val({tag, "_nwrites"}, act_q.size(), exp_q.size());
    nw = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      check_val($sformatf("%s_w%0d_addr", tag, i), act_q[i][67:36], exp_q[i][67:36]);
      check_val($sformatf("%s_w%0d_data", tag, i), act_q[i][35:4], exp_q[i][35:4]);
      check_val($sformatf("%s_w%0d_strb", tag, i), 32'(act_q[i][3:0]), 32'(exp_q[i][3:0]));
    end
    check_val({tag, "_done"}, done, exp_done);
    check_val({tag, "_err"}, err, exp_err);
    check_val({tag, "_core_rst_n"}, core_rst_n, exp_done);
    check_val({tag, "_rx_ready"}, rx_ready, 0);
    check_val({tag, "_rstn_during_we"}, rstn_during_we, 0);
    if (exp_done) begin
      check_val({tag, "_done_cyc"}, done_cyc, last_acc_cyc);
      if (exp_q.size() > 0 && !CSUM_EN) begin
        check_val({tag, "_last_we_cyc"}, last_we_cyc, last_acc_cyc);
        check_val({tag, "_done_at_we"}, done_at_we, 1);
        check_val({tag, "_rstn_cyc"}, rstn_cyc, last_acc_cyc + 1);
      end else begin
        check_val({tag, "_rstn_cyc"}, rstn_cyc, last_acc_cyc);
      end
    end
    nw = act_q.size();
    send_byte(8'h5A, 4, ok);
    check_val({tag, "_late_byte"}, ok, 0);
    repeat (2) begin @(posedge clk); #1; end
    check_val({tag, "_late_writes"}, act_q.size(), nw);
    $display("frame %s: bytes=%0d accepted=%0d writes=%0d done=%0d err=%0d",
             tag, tx_q.size(), acc_n, act_q.size(), done, err);
  endtask

  task automatic image1();
    logic [7:0] p[8] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    build_header(32'h8000_0000, 32'd8);
    foreach (p[i]) tx_q.push_back(p[i]);
  endtask

  initial begin
    bit ok;
    logic [31:0] base, len, room;
    int r;
    #2;

    do_reset();
    image1(); add_trailer(1'b0);
    run_frame("img1", 0);
    if (act_q.size() == 2) begin
      check_val("img1_w0_const", act_q[0][35:4], 32'h0010_0093);
      check_val("img1_w1_const", act_q[1][67:36], 32'h8000_0004);
    end else begin
      check_val("img1_const_count", act_q.size(), 2);
    end

    do_reset();
    build_header(32'h8000_0400, 32'd5);
    tx_q.push_back(8'h78); tx_q.push_back(8'h56); tx_q.push_back(8'h34);
    tx_q.push_back(8'h12); tx_q.push_back(8'hAA);
    add_trailer(1'b0);
    run_frame("img2", 0);
    if (act_q.size() == 2) begin
      check_val("img2_w1_const", act_q[1][35:4], 32'h0000_00AA);
      check_val("img2_w1_strb", 32'(act_q[1][3:0]), 32'h1);
    end

    do_reset(); build_header(32'h8000_0002, 32'd4); add_payload(4); run_frame("misalign", 0);
    do_reset(); build_header(32'h8000_2020, 32'd8); add_payload(8); run_frame("overrun", 0);
    do_reset(); build_header(32'h7FFF_FFFC, 32'd4); add_payload(4); run_frame("below", 0);
    do_reset(); build_header(32'h8000_2020, 32'd4); add_payload(4); add_trailer(1'b0);
    run_frame("top_word", 0);
    do_reset(); build_header(32'h8000_2024, 32'd0); add_trailer(1'b0); run_frame("len0_end", 0);
    do_reset(); build_header(32'h8000_2028, 32'd0); run_frame("len0_past", 0);
    do_reset(); build_header(32'h8000_0010, 32'hFFFF_FFFC); add_payload(4); run_frame("wrap", 0);
    do_reset(); image1(); add_trailer(1'b0); run_frame("img1_toggle", 1);

    // Reset after three payload bytes, then resend the whole image.
    do_reset(); image1();
    for (int i = 0; i < 11; i++) begin
      send_byte(tx_q[i], 6, ok);
      check_val("mid_accept", ok, 1);
    end
    @(posedge clk); #1;
    check_val("mid_no_write", act_q.size(), 0);
    check_val("mid_core_rst_n", core_rst_n, 0);
    do_reset(); image1(); add_trailer(1'b0); run_frame("img1_after_rst", 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Payload XOR of the first image is 0xB1.
    do_reset(); image1(); tx_q.push_back(8'hB1); run_frame("csum_good", 0);
    do_reset(); image1(); tx_q.push_back(8'hB0); run_frame("csum_bad", 0);
    do_reset(); build_header(32'h8000_0100, 32'd0); tx_q.push_back(8'h00); run_frame("csum_len0", 0);
`endif

    for (int t = 0; t < 40; t++) begin
      do_reset();
      r = int'($urandom_range(0, 9));
      base = MEM_BASE + 32'(4 * $urandom_range(0, int'(MEM_SIZE / 4) - 1));
      room = 32'(MEM_END - 64'(base));
      case (r)
        0: begin build_header(base | 32'($urandom_range(1, 3)), 32'd4); add_payload(4); end
        1: begin build_header(MEM_BASE - 32'(4 * $urandom_range(1, 16)), 32'd4); add_payload(4); end
        2: begin build_header(base, room + 32'($urandom_range(1, 8))); add_payload(4); end
        3: begin build_header(base, 32'hFFFF_FFFC); add_payload(4); end
        default: begin
          len = 32'($urandom_range(0, (room < 40) ? int'(room) : 40));
          build_header(base, len);
          add_payload(int'(len));
          add_trailer(CSUM_EN && ($urandom_range(0, 3) == 0));
        end
      endcase
      run_frame($sformatf("rand%0d", t), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
